// File: rtl/mac62_pkg.sv
// Shared constants, sign-magnitude types and conversion helpers for the
// 62-lane sign-magnitude multiply-accumulate datapath.
package mac62_pkg;

   localparam int N_LANES     = 62;
   localparam int MAG_W       = 7;
   localparam int OUT_W       = 21;
   localparam int PSUM_GROUPS = 4;
   localparam int GROUP_LANES = 16;
   localparam int PROD_W      = 2 * MAG_W;
   localparam int BUS_W       = 8 * N_LANES;

   typedef struct packed {
      logic             sign;
      logic [MAG_W-1:0] mag;
   } sm8_t;

   typedef struct packed {
      logic             sign;
      logic [OUT_W-2:0] mag;
   } sm21_t;

   // Sign-magnitude product to 21-bit two's complement; -0 maps to 0.
   function automatic logic signed [OUT_W-1:0] sm_to_tc(input logic sign,
                                                        input logic [PROD_W-1:0] mag);
      logic signed [OUT_W-1:0] ext;
      ext = $signed({{(OUT_W-PROD_W){1'b0}}, mag});
      if (sign) begin
         sm_to_tc = -ext;
      end else begin
         sm_to_tc = ext;
      end
   endfunction

   // Two's complement sum to sign-magnitude; zero always comes out as +0.
   function automatic sm21_t tc_to_sm(input logic signed [OUT_W-1:0] v);
      logic signed [OUT_W-1:0] neg;
      sm21_t                   res;
      neg = -v;
      if (v < $signed(21'sd0)) begin
         res.sign = 1'b1;
         res.mag  = neg[OUT_W-2:0];
      end else begin
         res.sign = 1'b0;
         res.mag  = v[OUT_W-2:0];
      end
      tc_to_sm = res;
   endfunction

endpackage

// File: rtl/mac62_if.sv
// Vector-in / result-out bundle of the 62-lane MAC.
interface mac62_if;
   import mac62_pkg::*;

   logic                 in_valid;
   logic [BUS_W-1:0]     a;
   logic [BUS_W-1:0]     w;
   logic                 out_valid;
   logic [OUT_W-1:0]     out;

   modport master (output in_valid, output a, output w, input out_valid, input out);
   modport slave  (input in_valid, input a, input w, output out_valid, output out);

endinterface

// File: rtl/mac62_lane_mul.sv
// One sign-magnitude 8x8 lane multiplier producing a 21-bit two's-complement
// product, ready to feed the adder tree.
module mac62_lane_mul
   import mac62_pkg::*;
(
   input  sm8_t                    a,
   input  sm8_t                    w,
   output logic signed [OUT_W-1:0] prod
);

   logic [PROD_W-1:0] mag;

   assign mag  = {{MAG_W{1'b0}}, a.mag} * {{MAG_W{1'b0}}, w.mag};
   assign prod = sm_to_tc(a.sign ^ w.sign, mag);

endmodule

// File: rtl/mac62_pipe.sv
// 62-lane sign-magnitude multiply-accumulate, one vector per cycle.
// Stage 1 holds four group partial sums, stage 2 the sign-magnitude result.
// Optional build macro MAC62_INPUT_REG_EN adds an input register stage
// (latency 3 instead of 2); arithmetic is the same in both builds.
module mac62_pipe
   import mac62_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   mac62_if.slave bus
);

   logic                    s0_valid;
   logic [BUS_W-1:0]        s0_a;
   logic [BUS_W-1:0]        s0_w;
   logic signed [OUT_W-1:0] prod [N_LANES];
   logic signed [OUT_W-1:0] psum_c [PSUM_GROUPS];
   logic signed [OUT_W-1:0] psum [PSUM_GROUPS];
   logic                    valid1;
   logic signed [OUT_W-1:0] total;
   sm21_t                   res;
   logic                    res_valid;

`ifdef MAC62_INPUT_REG_EN
   logic [BUS_W-1:0] in_a;
   logic [BUS_W-1:0] in_w;
   logic             in_v;

   // Input register stage; operands are only captured for valid vectors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_v <= 1'b0;
         in_a <= '0;
         in_w <= '0;
      end else begin
         in_v <= bus.in_valid;
         if (bus.in_valid) begin
            in_a <= bus.a;
            in_w <= bus.w;
         end else begin
            in_a <= in_a;
            in_w <= in_w;
         end
      end
   end

   assign s0_valid = in_v;
   assign s0_a     = in_a;
   assign s0_w     = in_w;
`else
   assign s0_valid = bus.in_valid;
   assign s0_a     = bus.a;
   assign s0_w     = bus.w;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N_LANES; gi++) begin : g_lane
         mac62_lane_mul u_mul (
            .a    (s0_a[8*gi +: 8]),
            .w    (s0_w[8*gi +: 8]),
            .prod (prod[gi])
         );
      end
   endgenerate

   // Group adder trees: lanes 0-15, 16-31, 32-47, 48-61.
   always_comb begin
      for (int g = 0; g < PSUM_GROUPS; g++) begin
         psum_c[g] = '0;
         for (int l = 0; l < GROUP_LANES; l++) begin
            if (g * GROUP_LANES + l < N_LANES) begin
               psum_c[g] = psum_c[g] + prod[g * GROUP_LANES + l];
            end else begin
               psum_c[g] = psum_c[g];
            end
         end
      end
   end

   // Stage 1: register the partial sums of each accepted vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid1 <= 1'b0;
         for (int g = 0; g < PSUM_GROUPS; g++) begin
            psum[g] <= '0;
         end
      end else begin
         valid1 <= s0_valid;
         for (int g = 0; g < PSUM_GROUPS; g++) begin
            if (s0_valid) begin
               psum[g] <= psum_c[g];
            end else begin
               psum[g] <= psum[g];
            end
         end
      end
   end

   assign total = psum[0] + psum[1] + psum[2] + psum[3];

   // Stage 2: final sum in sign-magnitude; result held between valid pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res       <= '0;
      end else begin
         res_valid <= valid1;
         if (valid1) begin
            res <= tc_to_sm(total);
         end else begin
            res <= res;
         end
      end
   end

   assign bus.out_valid = res_valid;
   assign bus.out       = res;

endmodule

// File: tb/tb_mac62_pipe.sv
// Directed, table-driven bench for mac62_pipe plus back-to-back and
// reset-in-flight sequences.
module tb_mac62_pipe;

`ifdef MAC62_INPUT_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam int NV = 9;

   typedef struct {
      string        name;
      logic [495:0] a;
      logic [495:0] w;
      logic [20:0]  exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   vec_t tbl [NV];

   mac62_if bus ();

   mac62_pipe dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [495:0] set_lane(input logic [495:0] v, input int idx,
                                             input logic [7:0] b);
      logic [495:0] r;
      r = v;
      r[8*idx +: 8] = b;
      return r;
   endfunction

   task automatic check(input string nm, input logic [20:0] act, input logic [20:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [495:0] av, input logic [495:0] wv);
      bus.in_valid = v;
      bus.a        = av;
      bus.w        = wv;
   endtask

   initial begin
      logic [495:0] z;
      logic [495:0] junk;
      n_checks = 0;
      n_fail   = 0;
      z        = '0;
      junk     = {62{8'h7F}};

      // vector table
      tbl[0].name = "mixed4";
      tbl[0].a = set_lane(set_lane(set_lane(set_lane(z, 0, 8'h64), 1, 8'h5D), 2, 8'hE7), 3, 8'hFF);
      tbl[0].w = set_lane(set_lane(set_lane(set_lane(z, 0, 8'h85), 1, 8'h04), 2, 8'h83), 3, 8'h02);
      tbl[0].exp = {1'b1, 20'd73};
      tbl[1].name = "all_pos_max";
      tbl[1].a = {62{8'h7F}};
      tbl[1].w = {62{8'h7F}};
      tbl[1].exp = {1'b0, 20'd999998};
      tbl[2].name = "all_neg_w_max";
      tbl[2].a = {62{8'h7F}};
      tbl[2].w = {62{8'hFF}};
      tbl[2].exp = {1'b1, 20'd999998};
      tbl[3].name = "cancel_zero";
      tbl[3].a = set_lane(set_lane(z, 0, 8'h0A), 1, 8'h8A);
      tbl[3].w = set_lane(set_lane(z, 0, 8'h0A), 1, 8'h0A);
      tbl[3].exp = 21'd0;
      tbl[4].name = "all_minus_zero";
      tbl[4].a = {62{8'h80}};
      tbl[4].w = {62{8'h80}};
      tbl[4].exp = 21'd0;
      tbl[5].name = "neg_times_neg";
      tbl[5].a = {62{8'hFF}};
      tbl[5].w = {62{8'hFF}};
      tbl[5].exp = {1'b0, 20'd999998};
      tbl[6].name = "unit_neg";
      tbl[6].a = set_lane(z, 0, 8'h01);
      tbl[6].w = set_lane(z, 0, 8'h81);
      tbl[6].exp = {1'b1, 20'd1};
      tbl[7].name = "last_lane";
      tbl[7].a = set_lane(z, 61, 8'h7F);
      tbl[7].w = set_lane(z, 61, 8'h7F);
      tbl[7].exp = {1'b0, 20'd16129};
      tbl[8].name = "group_edge";
      tbl[8].a = set_lane(set_lane(z, 47, 8'h05), 48, 8'h82);
      tbl[8].w = set_lane(set_lane(z, 47, 8'h05), 48, 8'h03);
      tbl[8].exp = {1'b0, 20'd19};

      // reset state
      rst_n = 1'b0;
      drive(1'b0, z, z);
      #3;
      check("reset_out", bus.out, 21'd0);
      check("reset_valid", {20'd0, bus.out_valid}, 21'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_valid", {20'd0, bus.out_valid}, 21'd0);

      // table: one isolated vector at a time, junk on a/w while in_valid low
      for (int v = 0; v < NV; v++) begin
         @(negedge clk);
         drive(1'b1, tbl[v].a, tbl[v].w);
         for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            drive(1'b0, junk, junk);
            if (c == LAT - 1) begin
               check({tbl[v].name, "_early_valid"}, {20'd0, bus.out_valid}, 21'd0);
            end else if (c == LAT) begin
               check({tbl[v].name, "_valid"}, {20'd0, bus.out_valid}, 21'd1);
               check({tbl[v].name, "_out"}, bus.out, tbl[v].exp);
            end else if (c == LAT + 1) begin
               check({tbl[v].name, "_pulse_end"}, {20'd0, bus.out_valid}, 21'd0);
               check({tbl[v].name, "_hold"}, bus.out, tbl[v].exp);
            end
         end
      end

      // three back-to-back vectors
      @(negedge clk);
      drive(1'b1, tbl[0].a, tbl[0].w);
      for (int c = 1; c <= LAT + 4; c++) begin
         @(negedge clk);
         if (c == 1) begin
            drive(1'b1, tbl[1].a, tbl[1].w);
         end else if (c == 2) begin
            drive(1'b1, tbl[7].a, tbl[7].w);
         end else begin
            drive(1'b0, junk, junk);
         end
         if (c >= LAT && c <= LAT + 2) begin
            check("b2b_valid", {20'd0, bus.out_valid}, 21'd1);
            check("b2b_out", bus.out,
                  (c == LAT) ? tbl[0].exp : ((c == LAT + 1) ? tbl[1].exp : tbl[7].exp));
         end else if (c > LAT + 2) begin
            check("b2b_after_valid", {20'd0, bus.out_valid}, 21'd0);
            check("b2b_after_hold", bus.out, tbl[7].exp);
         end else begin
            check("b2b_before_valid", {20'd0, bus.out_valid}, 21'd0);
         end
      end

      // reset with vectors in flight
      @(negedge clk);
      drive(1'b1, tbl[1].a, tbl[1].w);
      @(negedge clk);
      drive(1'b1, tbl[2].a, tbl[2].w);
      @(posedge clk);
      #2;
      drive(1'b0, z, z);
      rst_n = 1'b0;
      #1;
      check("async_rst_out", bus.out, 21'd0);
      check("async_rst_valid", {20'd0, bus.out_valid}, 21'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= LAT + 3; c++) begin
         @(negedge clk);
         check("post_rst_valid", {20'd0, bus.out_valid}, 21'd0);
         check("post_rst_out", bus.out, 21'd0);
      end

      // pipeline works again after reset
      @(negedge clk);
      drive(1'b1, tbl[0].a, tbl[0].w);
      for (int c = 1; c <= LAT; c++) begin
         @(negedge clk);
         drive(1'b0, z, z);
      end
      check("post_rst_vec_valid", {20'd0, bus.out_valid}, 21'd1);
      check("post_rst_vec_out", bus.out, tbl[0].exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
